// File: rtl/marmot_tb_pkg.sv
// Shared types and helpers for the Marmot bench monitors: profiler FSM states,
// trap-vector PCs and a saturating increment.
package marmot_tb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        EXC  = 2'd2
    } state_t;

    localparam logic [31:0] TRAP_PC0 = 32'h0000_0000;
    localparam logic [31:0] TRAP_PC1 = 32'h0000_0002;

    // Increments value unless it already holds the all-ones pattern of the given width.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
        logic [63:0] all_ones;
        all_ones = ~({64{1'b1}} << width);
        return (value == all_ones) ? value : value + 64'd1;
    endfunction

endpackage

// File: rtl/pc_loop_profiler_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
    import marmot_tb_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         RSTB,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (RSTB) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= W'(sat_inc(64'(count), W));
        end
    end

endmodule

// File: rtl/pc_loop_profiler.sv
// Measures loop iterations from the core monitor PC stream: cycles per iteration,
// min/max, iteration count, and a sticky flag when the PC parks on a trap vector.
module pc_loop_profiler
    import marmot_tb_pkg::*;
#(
    parameter logic [31:0] MARKER_PC = 32'h2000_0000,
    parameter int          EXC_LIMIT = 100,
    parameter int          CNT_W     = 32
) (
    input  logic             clock,
    input  logic             RSTB,
    input  logic [31:0]      pc,
    input  logic             pc_valid,
    output logic             loop_done,
    output logic [CNT_W-1:0] loop_cycles,
    output logic [CNT_W-1:0] loop_count,
    output logic [CNT_W-1:0] min_cycles,
    output logic [CNT_W-1:0] max_cycles,
    output logic             exc_flag,
    output logic [1:0]       state
);

    localparam int               EXC_W      = $clog2(EXC_LIMIT + 2);
    localparam logic [EXC_W-1:0] EXC_THRESH = EXC_W'(EXC_LIMIT);

    state_t           cur;
    state_t           cur_dec;
    logic [31:0]      pc_prev;
    logic [CNT_W-1:0] cyc_cnt;
    logic [EXC_W-1:0] exc_cnt;
    logic [CNT_W-1:0] new_cycles;
    logic             hit;
    logic             trap;
    logic             exc_hit;
    logic             run_hit;

    // A hit is an entry onto the marker, so a PC stalled on it counts only once.
    always_comb begin
        cur_dec    = (cur == RUN || cur == EXC) ? cur : IDLE;
        hit        = pc_valid && (pc == MARKER_PC) && (pc != pc_prev);
        trap       = pc_valid && (pc == TRAP_PC0 || pc == TRAP_PC1);
        exc_hit    = trap && (cur_dec != EXC) && (exc_cnt >= EXC_THRESH);
        run_hit    = (cur_dec == RUN) && hit && !exc_hit;
        new_cycles = CNT_W'(sat_inc(64'(cyc_cnt), CNT_W));
    end

    always_ff @(posedge clock) begin
        if (RSTB) begin
            pc_prev <= '0;
        end else if (pc_valid) begin
            pc_prev <= pc;
        end
    end

    sat_counter #(.W(CNT_W)) u_cyc_cnt (
        .clock (clock),
        .RSTB  (RSTB),
        .clr   (hit && cur_dec != EXC),
        .inc   (cur_dec == RUN),
        .count (cyc_cnt)
    );

    sat_counter #(.W(CNT_W)) u_loop_count (
        .clock (clock),
        .RSTB  (RSTB),
        .clr   (1'b0),
        .inc   (run_hit),
        .count (loop_count)
    );

    // Invalid cycles neither extend nor break a run of trap-vector PCs.
    sat_counter #(.W(EXC_W)) u_exc_cnt (
        .clock (clock),
        .RSTB  (RSTB),
        .clr   (pc_valid && !trap),
        .inc   (trap),
        .count (exc_cnt)
    );

    always_ff @(posedge clock) begin
        if (RSTB) begin
            cur         <= IDLE;
            loop_done   <= 1'b0;
            loop_cycles <= '0;
            min_cycles  <= '1;
            max_cycles  <= '0;
            exc_flag    <= 1'b0;
        end else begin
            loop_done <= 1'b0;
            if (exc_hit) begin
                cur      <= EXC;
                exc_flag <= 1'b1;
            end else begin
                case (cur_dec)
                    IDLE: begin
                        cur <= hit ? RUN : IDLE;
                    end
                    RUN: begin
                        if (run_hit) begin
                            loop_done   <= 1'b1;
                            loop_cycles <= new_cycles;
                            if (new_cycles < min_cycles) min_cycles <= new_cycles;
                            if (new_cycles > max_cycles) max_cycles <= new_cycles;
                        end
                    end
                    EXC: begin
                        cur <= EXC;
                    end
                    default: begin
                        cur <= IDLE;
                    end
                endcase
            end
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_pc_loop_profiler.sv
// Randomized bench for pc_loop_profiler: a 32-bit and a 4-bit instance share one PC
// stream and are compared against a timestamp-based reference model.
module tb_pc_loop_profiler;

    localparam logic [31:0] MARKER    = 32'h2000_0000;
    localparam int          EXC_LIMIT = 4;

    logic        clock;
    logic        RSTB;
    logic [31:0] pc;
    logic        pc_valid;

    logic        done_a, flag_a;
    logic [31:0] cycles_a, count_a, min_a, max_a;
    logic [1:0]  state_a;
    logic        done_b, flag_b;
    logic [3:0]  cycles_b, count_b, min_b, max_b;
    logic [1:0]  state_b;

    int checks = 0;
    int errors = 0;

    pc_loop_profiler #(.MARKER_PC(MARKER), .EXC_LIMIT(EXC_LIMIT), .CNT_W(32)) dut_a (
        .clock(clock), .RSTB(RSTB), .pc(pc), .pc_valid(pc_valid),
        .loop_done(done_a), .loop_cycles(cycles_a), .loop_count(count_a),
        .min_cycles(min_a), .max_cycles(max_a), .exc_flag(flag_a), .state(state_a)
    );

    pc_loop_profiler #(.MARKER_PC(MARKER), .EXC_LIMIT(EXC_LIMIT), .CNT_W(4)) dut_b (
        .clock(clock), .RSTB(RSTB), .pc(pc), .pc_valid(pc_valid),
        .loop_done(done_b), .loop_cycles(cycles_b), .loop_count(count_b),
        .min_cycles(min_b), .max_cycles(max_b), .exc_flag(flag_b), .state(state_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: iteration length is the distance between hit edge indices.
    longint      m_mask[2] = '{64'hFFFF_FFFF, 64'hF};
    longint      edge_idx = 0;
    logic [31:0] m_prev = '0;
    int          m_exc_run = 0;
    int          m_state[2];
    longint      m_last[2], m_cycles[2], m_count[2], m_min[2], m_max[2];
    bit          m_done[2], m_flag[2];

    always @(posedge clock) begin : model
        bit hit, trap;
        edge_idx++;
        if (RSTB) begin
            m_prev    = '0;
            m_exc_run = 0;
            for (int d = 0; d < 2; d++) begin
                m_state[d] = 0; m_last[d] = 0; m_cycles[d] = 0; m_count[d] = 0;
                m_min[d] = m_mask[d]; m_max[d] = 0; m_done[d] = 0; m_flag[d] = 0;
            end
        end else begin
            hit  = 0;
            trap = 0;
            if (pc_valid) begin
                hit  = (pc == MARKER) && (pc != m_prev);
                trap = (pc == 32'h0) || (pc == 32'h2);
            end
            if (trap) m_exc_run++;
            else if (pc_valid) m_exc_run = 0;
            for (int d = 0; d < 2; d++) begin
                longint k;
                m_done[d] = 0;
                if (m_state[d] == 2) begin
                    m_state[d] = 2;
                end else if (m_exc_run > EXC_LIMIT) begin
                    m_state[d] = 2;
                    m_flag[d]  = 1;
                end else if (hit && m_state[d] == 0) begin
                    m_state[d] = 1;
                    m_last[d]  = edge_idx;
                end else if (hit) begin
                    k = edge_idx - m_last[d];
                    m_cycles[d] = (k > m_mask[d]) ? m_mask[d] : k;
                    m_count[d]  = (m_count[d] < m_mask[d]) ? m_count[d] + 1 : m_mask[d];
                    if (m_cycles[d] < m_min[d]) m_min[d] = m_cycles[d];
                    if (m_cycles[d] > m_max[d]) m_max[d] = m_cycles[d];
                    m_done[d] = 1;
                    m_last[d] = edge_idx;
                end
            end
            if (pc_valid) m_prev = pc;
        end
    end

    // Cycle-by-cycle trace of both instances against the model; tasks inspect the tally.
    int          trace_err = 0;
    int          trace_base = 0;
    string       last_name = "none";
    logic [31:0] last_act = '0;
    logic [31:0] last_exp = '0;

    function automatic void trace_cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            trace_err++;
            last_name = name;
            last_act  = act;
            last_exp  = exp;
        end
    endfunction

    always @(negedge clock) begin
        trace_cmp("a.loop_done",   32'(done_a),   32'(m_done[0]));
        trace_cmp("a.loop_cycles", cycles_a,      32'(m_cycles[0]));
        trace_cmp("a.loop_count",  count_a,       32'(m_count[0]));
        trace_cmp("a.min_cycles",  min_a,         32'(m_min[0]));
        trace_cmp("a.max_cycles",  max_a,         32'(m_max[0]));
        trace_cmp("a.exc_flag",    32'(flag_a),   32'(m_flag[0]));
        trace_cmp("a.state",       32'(state_a),  32'(m_state[0]));
        trace_cmp("b.loop_done",   32'(done_b),   32'(m_done[1]));
        trace_cmp("b.loop_cycles", 32'(cycles_b), 32'(m_cycles[1]));
        trace_cmp("b.loop_count",  32'(count_b),  32'(m_count[1]));
        trace_cmp("b.min_cycles",  32'(min_b),    32'(m_min[1]));
        trace_cmp("b.max_cycles",  32'(max_b),    32'(m_max[1]));
        trace_cmp("b.exc_flag",    32'(flag_b),   32'(m_flag[1]));
        trace_cmp("b.state",       32'(state_b),  32'(m_state[1]));
    end

    function automatic logic [31:0] rand_pc();
        return 32'h0000_1000 + ($urandom_range(0, 1023) << 2);
    endfunction

    task automatic check_trace(input string tag);
        checks++;
        if (trace_err != trace_base) begin
            errors++;
            $display("FAIL trace_%s: %0d model mismatches, last %s actual=%0h required=%0h",
                     tag, trace_err - trace_base, last_name, last_act, last_exp);
        end
        trace_base = trace_err;
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            RSTB = 1'b1; pc_valid = 1'b1;
            pc = (i % 2 == 1) ? MARKER : rand_pc();
        end
        @(negedge clock);
        RSTB = 1'b0; pc_valid = 1'b1; pc = rand_pc();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            RSTB = 1'b1; pc_valid = 1'b1;
            pc = (i == 1) ? MARKER : ((i == 2) ? 32'h0 : rand_pc());
        end
        @(negedge clock);
        checks += 7;
        if (done_a !== 1'b0)          begin errors++; $display("FAIL reset_done: got %0d expected 0", done_a); end
        if (cycles_a !== 32'd0)       begin errors++; $display("FAIL reset_cycles: got %0d expected 0", cycles_a); end
        if (count_a !== 32'd0)        begin errors++; $display("FAIL reset_count: got %0d expected 0", count_a); end
        if (min_a !== 32'hFFFF_FFFF)  begin errors++; $display("FAIL reset_min: got %0h expected ffffffff", min_a); end
        if (max_a !== 32'd0)          begin errors++; $display("FAIL reset_max: got %0d expected 0", max_a); end
        if (flag_a !== 1'b0)          begin errors++; $display("FAIL reset_flag: got %0d expected 0", flag_a); end
        if (state_a !== 2'd0)         begin errors++; $display("FAIL reset_state: got %0d expected 0", state_a); end
        checks += 2;
        if (min_b !== 4'hF)           begin errors++; $display("FAIL reset_min_b: got %0h expected f", min_b); end
        if (count_b !== 4'd0)         begin errors++; $display("FAIL reset_count_b: got %0d expected 0", count_b); end
        RSTB = 1'b0; pc = rand_pc();
        check_trace("reset");
    endtask

    task automatic test_steady_loop();
        int pulse_t[$];
        logic [31:0] pulse_c[$];
        int want_t[3] = '{111, 211, 331};
        logic [31:0] want_c[3] = '{32'd100, 32'd100, 32'd120};
        do_reset(2);
        for (int t = 0; t <= 340; t++) begin
            @(negedge clock);
            if (done_a) begin pulse_t.push_back(t); pulse_c.push_back(cycles_a); end
            pc = (t == 10 || t == 110 || t == 210 || t == 330) ? MARKER : rand_pc();
            pc_valid = 1'b1;
        end
        checks++;
        if (pulse_t.size() != 3) begin
            errors++; $display("FAIL steady_pulses: got %0d expected 3", pulse_t.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks += 2;
                if (pulse_t[i] != want_t[i]) begin errors++; $display("FAIL steady_pulse_time: got %0d expected %0d", pulse_t[i], want_t[i]); end
                if (pulse_c[i] !== want_c[i]) begin errors++; $display("FAIL steady_cycles: got %0d expected %0d", pulse_c[i], want_c[i]); end
            end
        end
        checks += 5;
        if (count_a !== 32'd3)   begin errors++; $display("FAIL steady_count: got %0d expected 3", count_a); end
        if (min_a !== 32'd100)   begin errors++; $display("FAIL steady_min: got %0d expected 100", min_a); end
        if (max_a !== 32'd120)   begin errors++; $display("FAIL steady_max: got %0d expected 120", max_a); end
        if (state_a !== 2'd1)    begin errors++; $display("FAIL steady_state: got %0d expected 1", state_a); end
        if (cycles_b !== 4'd15)  begin errors++; $display("FAIL steady_cycles_b: got %0d expected 15", cycles_b); end
        check_trace("steady");
    endtask

    task automatic test_stalled_marker();
        int pulses = 0;
        do_reset(2);
        for (int t = 0; t <= 62; t++) begin
            @(negedge clock);
            if (done_a) pulses++;
            pc = ((t >= 5 && t < 10) || t == 55) ? MARKER : rand_pc();
            pc_valid = 1'b1;
        end
        checks += 3;
        if (pulses != 1)         begin errors++; $display("FAIL stall_pulses: got %0d expected 1", pulses); end
        if (cycles_a !== 32'd50) begin errors++; $display("FAIL stall_cycles: got %0d expected 50", cycles_a); end
        if (count_a !== 32'd1)   begin errors++; $display("FAIL stall_count: got %0d expected 1", count_a); end
        check_trace("stall");
    endtask

    task automatic test_exception();
        int pulses = 0;
        do_reset(2);
        for (int t = 0; t <= 70; t++) begin
            @(negedge clock);
            if (done_a) pulses++;
            if (t == 34) begin
                checks++;
                if (flag_a !== 1'b0) begin errors++; $display("FAIL exc_early: got %0d expected 0", flag_a); end
            end
            if (t == 35) begin
                checks += 3;
                if (flag_a !== 1'b1)  begin errors++; $display("FAIL exc_flag: got %0d expected 1", flag_a); end
                if (state_a !== 2'd2) begin errors++; $display("FAIL exc_state: got %0d expected 2", state_a); end
                if (flag_b !== 1'b1)  begin errors++; $display("FAIL exc_flag_b: got %0d expected 1", flag_b); end
            end
            if (t >= 30 && t <= 34) pc = ($urandom_range(0, 1) == 1) ? 32'h2 : 32'h0;
            else if (t == 3 || t == 23 || t == 40 || t == 45 || t == 60) pc = MARKER;
            else pc = rand_pc();
            pc_valid = 1'b1;
        end
        checks += 4;
        if (pulses != 1)         begin errors++; $display("FAIL exc_pulses: got %0d expected 1", pulses); end
        if (count_a !== 32'd1)   begin errors++; $display("FAIL exc_frozen_count: got %0d expected 1", count_a); end
        if (cycles_a !== 32'd20) begin errors++; $display("FAIL exc_frozen_cycles: got %0d expected 20", cycles_a); end
        if (flag_a !== 1'b1)     begin errors++; $display("FAIL exc_sticky: got %0d expected 1", flag_a); end
        check_trace("exception");
    endtask

    task automatic test_no_exception();
        do_reset(2);
        for (int t = 0; t <= 20; t++) begin
            @(negedge clock);
            if ((t >= 5 && t <= 8) || (t >= 10 && t <= 13)) pc = 32'h0;
            else if (t == 9) pc = 32'h100;
            else pc = rand_pc();
            pc_valid = 1'b1;
        end
        checks += 2;
        if (flag_a !== 1'b0)  begin errors++; $display("FAIL noexc_flag: got %0d expected 0", flag_a); end
        if (state_a !== 2'd0) begin errors++; $display("FAIL noexc_state: got %0d expected 0", state_a); end
        check_trace("no_exception");
    endtask

    task automatic test_invalid_gaps();
        do_reset(2);
        for (int t = 0; t <= 100; t++) begin
            @(negedge clock);
            if (t == 63) begin
                checks += 2;
                if (done_a !== 1'b1)     begin errors++; $display("FAIL gap_pulse: got %0d expected 1", done_a); end
                if (cycles_a !== 32'd60) begin errors++; $display("FAIL gap_cycles: got %0d expected 60", cycles_a); end
            end
            if (t == 94) begin
                checks++;
                if (flag_a !== 1'b0) begin errors++; $display("FAIL gap_exc_early: got %0d expected 0", flag_a); end
            end
            if (t == 95) begin
                checks++;
                if (flag_a !== 1'b1) begin errors++; $display("FAIL gap_exc_hold: got %0d expected 1", flag_a); end
            end
            if ((t >= 10 && t <= 29) || (t >= 73 && t <= 92)) begin
                pc = 'x; pc_valid = 1'b0;
            end else begin
                pc_valid = 1'b1;
                if (t == 2 || t == 62) pc = MARKER;
                else if ((t >= 70 && t <= 72) || t == 93 || t == 94) pc = 32'h0;
                else pc = rand_pc();
            end
        end
        check_trace("gaps");
    endtask

    task automatic test_saturation_reset();
        do_reset(2);
        for (int t = 0; t <= 335; t++) begin
            @(negedge clock);
            pc = (t >= 5 && (t - 5) % 20 == 0 && t <= 325) ? MARKER : rand_pc();
            pc_valid = 1'b1;
        end
        checks += 4;
        if (cycles_b !== 4'd15)  begin errors++; $display("FAIL sat_cycles_b: got %0d expected 15", cycles_b); end
        if (count_b !== 4'd15)   begin errors++; $display("FAIL sat_count_b: got %0d expected 15", count_b); end
        if (count_a !== 32'd16)  begin errors++; $display("FAIL sat_count_a: got %0d expected 16", count_a); end
        if (cycles_a !== 32'd20) begin errors++; $display("FAIL sat_cycles_a: got %0d expected 20", cycles_a); end
        @(negedge clock);
        RSTB = 1'b1; pc = MARKER;
        @(negedge clock);
        checks += 6;
        if (state_a !== 2'd0)        begin errors++; $display("FAIL midreset_state: got %0d expected 0", state_a); end
        if (count_a !== 32'd0)       begin errors++; $display("FAIL midreset_count: got %0d expected 0", count_a); end
        if (cycles_a !== 32'd0)      begin errors++; $display("FAIL midreset_cycles: got %0d expected 0", cycles_a); end
        if (min_a !== 32'hFFFF_FFFF) begin errors++; $display("FAIL midreset_min: got %0h expected ffffffff", min_a); end
        if (max_a !== 32'd0)         begin errors++; $display("FAIL midreset_max: got %0d expected 0", max_a); end
        if (count_b !== 4'd0)        begin errors++; $display("FAIL midreset_count_b: got %0d expected 0", count_b); end
        RSTB = 1'b0; pc = rand_pc();
        check_trace("saturation");
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 5; seg++) begin
            do_reset(1 + seg % 2);
            for (int t = 0; t < 300; t++) begin
                int r;
                @(negedge clock);
                r = $urandom_range(0, 99);
                pc_valid = 1'b1;
                if (r < 12) pc = MARKER;
                else if (r < 22) pc = ($urandom_range(0, 1) == 1) ? 32'h2 : 32'h0;
                else if (r < 32) begin pc = 'x; pc_valid = 1'b0; end
                else pc = rand_pc();
            end
            @(negedge clock);
            checks += 2;
            if (count_a !== 32'(m_count[0])) begin errors++; $display("FAIL random_count: got %0d expected %0d", count_a, m_count[0]); end
            if (flag_a !== m_flag[0])        begin errors++; $display("FAIL random_flag: got %0d expected %0d", flag_a, m_flag[0]); end
            check_trace("random");
        end
    endtask

    initial begin
        RSTB = 1'b1;
        pc = '0;
        pc_valid = 1'b0;
        test_reset();
        test_steady_loop();
        test_stalled_marker();
        test_exception();
        test_no_exception();
        test_invalid_gaps();
        test_saturation_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_loop_profiler.md
# pc_loop_profiler

Cycle-accurate profiler that consumes the Rocket core's retired/monitor PC stream and measures benchmark loop iterations, for example Dhrystone `Proc_6`, entirely in hardware-style RTL. It sits directly downstream of the core monitor PC tap in the Marmot Caravel bench and replaces ad-hoc per-test `always` blocks. It reports:
- cycles per iteration, with min and max;
- a completed-loop count;
- a sticky exception flag (PC parked at trap vector).

Outputs are consumed by the bench's reporting and finish logic.

## Interface
Parameters:
- `MARKER_PC`, default 32'h2000_0000: PC that marks one loop iteration. Must be nonzero and not 2.
- `EXC_LIMIT`, default 100: allowed consecutive trap-vector PCs before the exception is raised.
- `CNT_W`, default 32: width of the cycle and loop counters.

Ports:
- `clock`, in, 1: clock. All logic is on the rising edge.
- `RSTB`, in, 1: reset, synchronous, active-high.
- `pc`, in, 32: core monitor PC.
- `pc_valid`, in, 1: `pc` is meaningful this cycle. 0 during core reset or X.
- `loop_done`, out, 1: one-cycle pulse when an iteration completes.
- `loop_cycles`, out, `CNT_W`: cycles of the last completed iteration. Held between pulses.
- `loop_count`, out, `CNT_W`: number of completed iterations.
- `min_cycles`, out, `CNT_W`: minimum `loop_cycles` seen.
- `max_cycles`, out, `CNT_W`: maximum `loop_cycles` seen.
- `exc_flag`, out, 1: sticky. The exception condition has been detected.
- `state`, out, 2: FSM state, for bench debug.

## Operation
- Hit condition, sampled when `pc_valid`=1: `pc == MARKER_PC && pc != pc_prev`. This is an edge-qualified entry to the marker, so a stalled PC is counted once.
- `pc_prev` loads `pc` only when `pc_valid`=1. It resets to 0.
- States are `IDLE`=0, `RUN`=1, `EXC`=2. Encoding 3 is unused and decodes to `IDLE`.
- `IDLE`:
  - On a hit, go to `RUN` and clear `cyc_cnt` to 0.
  - The first hit completes no iteration: no `loop_done`.
- `RUN`:
  - `cyc_cnt` increments every cycle, independent of `pc_valid`, and saturates at all-ones.
  - On a hit: `loop_cycles` <= sat(`cyc_cnt`+1), `cyc_cnt` <= 0, `loop_count` <= sat(`loop_count`+1), update min/max, pulse `loop_done`.
- Exception detect, active in every state:
  - `exc_cnt` counts consecutive valid cycles with `pc` equal to 0 or 2. A valid cycle with any other PC clears it.
  - `pc_valid`=0 holds `exc_cnt`.
  - When `exc_cnt` reaches `EXC_LIMIT`+1, go to `EXC` and set `exc_flag`.
- `EXC`:
  - Terminal until reset.
  - No further `loop_done`. All statistics are frozen.
- Simultaneous hit and exception threshold: the exception wins. No `loop_done` fires and statistics are not updated.
- Saturation: `loop_cycles`, `loop_count` and `cyc_cnt` never wrap. All-ones means overflow.
- Min/max: compare against the new `loop_cycles` value. The first completed iteration sets both.

## Timing
- Reset values:
  - `loop_done`=0, `loop_cycles`=0, `loop_count`=0.
  - `min_cycles`=all-ones, `max_cycles`=0.
  - `exc_flag`=0, `state`=`IDLE`.
  - Internal: `cyc_cnt`=0, `exc_cnt`=0, `pc_prev`=0.
- Reset asserted mid-operation returns everything to the reset values on the next edge. `RSTB` has priority over all updates.
- Latency: a hit sampled at edge N drives `loop_done`=1 and the updated `loop_cycles`, `loop_count`, `min_cycles`, `max_cycles` after edge N. They are visible in cycle N+1 and the pulse lasts exactly one cycle.
- Hits at edges N and N+K give `loop_cycles`=K.
- The minimum legal K is 2, because the marker PC must be left and re-entered. K=1 is impossible by the edge qualification.
- `exc_flag` rises one cycle after the (`EXC_LIMIT`+1)th consecutive trap PC is sampled.
- All outputs are registered. There are no combinational input-to-output paths.

## Structure
- Shared package `marmot_tb_pkg` holds:
  - the state enum (`IDLE`/`RUN`/`EXC`);
  - `TRAP_PC0`=32'h0 and `TRAP_PC1`=32'h2;
  - a function `sat_inc(value, width)`.
- One natural sub-module: `sat_counter`, parameterized width, with `clr`/`inc` inputs. Instantiate it for `cyc_cnt`, `loop_count` and `exc_cnt`.
- Target size: about 150–250 lines of RTL.

## Test plan
- **Reset defaults:** assert `RSTB` for 3 cycles with `pc` toggling -> all outputs equal the reset values; `min_cycles`=32'hFFFF_FFFF.
- **Steady loop:** `MARKER_PC` visited at edges 10, 110, 210, 330 -> three `loop_done` pulses, at cycles 111, 211 and 331:
  - `loop_cycles` = 100, 100, 120;
  - `loop_count`=3, `min_cycles`=100, `max_cycles`=120.
- **Stalled marker:** `pc` held at `MARKER_PC` for 5 cycles, then left and re-entered 50 cycles after the first entry -> one iteration with `loop_cycles`=50, no extra pulse.
- **Exception:** `EXC_LIMIT`=4, `pc`=0 for 5 consecutive valid cycles -> `exc_flag`=1 one cycle later and `state`=`EXC`; a later marker hit produces no `loop_done`.
  - Same setup, but `pc`=0 for 4 cycles then 0x100 -> no exception.
- **Invalid gaps:** `pc_valid`=0 for 20 cycles mid-loop with `pc`=X -> `cyc_cnt` keeps counting, `exc_cnt` holds, and the next hit reports the full elapsed cycles.
- **Saturation and reset mid-run:** `CNT_W`=4, hits 20 cycles apart -> `loop_cycles`=15. Assert `RSTB` in the middle of a loop -> next cycle all stats are back at reset values and `state`=`IDLE`.
